// File: rtl/ms_counter_pkg.sv
// Shared definitions for the millisecond tick controller and the counter chain it drives.
// Holds the run-state encoding and the default input clock frequency.
package ms_counter_pkg;

  localparam int DEFAULT_CLK_FREQ_HZ = 100000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Keeps counters at least one bit wide when a count range collapses to a single value.
  function automatic int counterWidth(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/ms_tick_ctrl_if.sv
// Button inputs and counter-chain control outputs of the millisecond tick controller.
// The master side presses buttons; the slave side is the controller itself.
interface ms_tick_ctrl_if;

  logic BTN_SS;
  logic BTN_CLR;
  logic TICK;
  logic CLR;
  logic RUNNING;

  modport master (
    output BTN_SS,
    output BTN_CLR,
    input  TICK,
    input  CLR,
    input  RUNNING
  );

  modport slave (
    input  BTN_SS,
    input  BTN_CLR,
    output TICK,
    output CLR,
    output RUNNING
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes a raw push-button, debounces it and emits a one-cycle pulse per accepted press.
// A button already held when reset is released must be let go before it can produce a press.
module btn_debounce
  import ms_counter_pkg::*;
#(
  parameter int DEB_CYCLES = 10
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btnRaw,
  output logic press
);

  localparam int CNT_W = counterWidth(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic syncQ1;
  logic syncQ2;
  logic stable;
  logic stablePrev;
  logic armed;
  logic [1:0] fillQ;
  logic [CNT_W-1:0] debCount;

  // fillQ marks when syncQ2 carries a real post-reset sample; only then may a low level arm the edge detector.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      syncQ1     <= 1'b0;
      syncQ2     <= 1'b0;
      stable     <= 1'b0;
      stablePrev <= 1'b0;
      armed      <= 1'b0;
      fillQ      <= 2'b00;
      debCount   <= '0;
      press      <= 1'b0;
    end else begin
      syncQ1     <= btnRaw;
      syncQ2     <= syncQ1;
      fillQ      <= {fillQ[0], 1'b1};
      stablePrev <= stable;
      if (syncQ2 == stable) begin
        debCount <= '0;
      end else if (debCount == CNT_LAST) begin
        stable   <= syncQ2;
        debCount <= '0;
      end else begin
        debCount <= debCount + CNT_W'(1);
      end
      if (fillQ[1] && !syncQ2 && !stable) begin
        armed <= 1'b1;
      end
      press <= armed && stable && !stablePrev;
    end
  end

endmodule

// File: rtl/ms_tick_ctrl.sv
// Stopwatch control: debounced start/stop and clear buttons drive an IDLE/RUN/PAUSE machine
// and a millisecond prescaler whose TICK enables the downstream flip-flop counter chain.
module ms_tick_ctrl
  import ms_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int DEBOUNCE_MS = 10
) (
  input logic           CLK,
  input logic           RST_N,
  ms_tick_ctrl_if.slave bus
);

  localparam int DIV        = CLK_FREQ_HZ / 1000;
  localparam int DEB_CYCLES = DEBOUNCE_MS * DIV;
  localparam int PRE_W      = counterWidth(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic ssPress;
  logic clrPress;
  state_t state;
  logic [PRE_W-1:0] prescaler;
  logic tickQ;
  logic clrQ;
  logic runningQ;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) ssDebounce (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .btnRaw (bus.BTN_SS),
    .press  (ssPress)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) clrDebounce (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .btnRaw (bus.BTN_CLR),
    .press  (clrPress)
  );

  // Clear outranks start/stop; the prescaler only moves in RUN so a pause keeps its partial count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      prescaler <= '0;
      tickQ     <= 1'b0;
      clrQ      <= 1'b0;
      runningQ  <= 1'b0;
    end else begin
      tickQ <= 1'b0;
      clrQ  <= 1'b0;
      if (clrPress) begin
        state     <= IDLE;
        prescaler <= '0;
        clrQ      <= 1'b1;
        runningQ  <= 1'b0;
      end else begin
        if (state == RUN) begin
          if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            tickQ     <= 1'b1;
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end
        if (ssPress) begin
          unique case (state)
            IDLE, PAUSE: begin
              state    <= RUN;
              runningQ <= 1'b1;
            end
            RUN: begin
              state    <= PAUSE;
              runningQ <= 1'b0;
            end
            default: begin
              state    <= IDLE;
              runningQ <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.TICK    = tickQ;
  assign bus.CLR     = clrQ;
  assign bus.RUNNING = runningQ;

endmodule

// File: tb/tb_ms_tick_ctrl.sv
// Directed bench for ms_tick_ctrl at 10 kHz with 1 ms debounce (DIV = 10, DEB_CYCLES = 10).
// Cycle c below means the rising edge at which an input set just before it is first sampled.
module tb_ms_tick_ctrl;

  logic CLK;
  logic RST_N;
  int   total;
  int   bad;
  logic prevTick;
  logic prevClr;

  ms_tick_ctrl_if bus ();

  ms_tick_ctrl #(
    .CLK_FREQ_HZ (10000),
    .DEBOUNCE_MS (1)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive both buttons just before the next rising edge, then return on the following falling edge.
  task automatic applyStimulus(input logic ss, input logic clr);
    bus.BTN_SS  = ss;
    bus.BTN_CLR = clr;
    @(negedge CLK);
  endtask

  task automatic resetDut();
    bus.BTN_SS  = 1'b0;
    bus.BTN_CLR = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  // TICK and CLR must be mutually exclusive and neither may last two cycles.
  always @(negedge CLK) begin
    checkOutput("tick/clr overlap", bus.TICK & bus.CLR, 1'b0);
    checkOutput("tick two cycles", prevTick & bus.TICK, 1'b0);
    checkOutput("clr two cycles", prevClr & bus.CLR, 1'b0);
    prevTick = bus.TICK;
    prevClr  = bus.CLR;
  end

  initial begin
    total = 0;
    bad = 0;
    prevTick = 1'b0;
    prevClr = 1'b0;
    bus.BTN_SS = 1'b0;
    bus.BTN_CLR = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("reset running", bus.RUNNING, 1'b0);
    checkOutput("reset tick", bus.TICK, 1'b0);
    checkOutput("reset clr", bus.CLR, 1'b0);

    $display("[TB] start/stop held from cycle 0");
    resetDut();
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("held running c=%0d", c), bus.RUNNING, c >= 13);
      checkOutput($sformatf("held tick c=%0d", c), bus.TICK, c inside {23, 33, 43, 53});
      checkOutput($sformatf("held clr c=%0d", c), bus.CLR, 1'b0);
    end

    $display("[TB] pause keeps partial prescaler count");
    resetDut();
    for (int c = 0; c < 111; c++) begin
      applyStimulus((c < 12) || (c >= 25 && c < 37) || (c >= 75 && c < 87), 1'b0);
      checkOutput($sformatf("pause running c=%0d", c), bus.RUNNING,
                  (c >= 13 && c < 38) || (c >= 88));
      checkOutput($sformatf("pause tick c=%0d", c), bus.TICK, c inside {23, 33, 93, 103});
      checkOutput($sformatf("pause clr c=%0d", c), bus.CLR, 1'b0);
    end

    $display("[TB] clear and start/stop together");
    resetDut();
    for (int c = 0; c < 91; c++) begin
      applyStimulus((c < 12) || (c >= 30 && c < 42) || (c >= 60 && c < 72),
                    (c >= 30 && c < 42));
      checkOutput($sformatf("clear running c=%0d", c), bus.RUNNING,
                  (c >= 13 && c < 43) || (c >= 73));
      checkOutput($sformatf("clear tick c=%0d", c), bus.TICK, c inside {23, 33, 83});
      checkOutput($sformatf("clear clr c=%0d", c), bus.CLR, c == 43);
    end

    $display("[TB] short glitches then minimum-length press");
    resetDut();
    for (int c = 0; c < 66; c++) begin
      applyStimulus((c < 6) || (c >= 20 && c < 29) || (c >= 40 && c < 50), 1'b0);
      checkOutput($sformatf("glitch running c=%0d", c), bus.RUNNING, c >= 53);
      checkOutput($sformatf("glitch tick c=%0d", c), bus.TICK, c == 63);
      checkOutput($sformatf("glitch clr c=%0d", c), bus.CLR, 1'b0);
    end

    $display("[TB] asynchronous reset mid-run");
    resetDut();
    for (int c = 0; c < 24; c++) begin
      applyStimulus(c < 12, 1'b0);
      checkOutput($sformatf("prereset running c=%0d", c), bus.RUNNING, c >= 13);
      checkOutput($sformatf("prereset tick c=%0d", c), bus.TICK, c == 23);
    end
    bus.BTN_SS = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    checkOutput("async reset running", bus.RUNNING, 1'b0);
    checkOutput("async reset tick", bus.TICK, 1'b0);
    checkOutput("async reset clr", bus.CLR, 1'b0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("held through reset running c=%0d", c), bus.RUNNING, 1'b0);
      checkOutput($sformatf("held through reset clr c=%0d", c), bus.CLR, 1'b0);
    end
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("released running c=%0d", c), bus.RUNNING, 1'b0);
    end
    for (int c = 0; c < 21; c++) begin
      applyStimulus(c < 12, 1'b0);
      checkOutput($sformatf("repress running c=%0d", c), bus.RUNNING, c >= 13);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms_tick_ctrl.md
MS_TICK_CTRL -- requirements
Module: ms_tick_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, input clock frequency in Hz; SHALL be an integer multiple of 1000.
REQ-002 Parameter DEBOUNCE_MS, default 10, button stable time in ms before a press is accepted.
REQ-003 CLK  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 BTN_SS  input  1  raw start/stop push-button, asynchronous to CLK, high = pressed.
REQ-006 BTN_CLR  input  1  raw clear push-button, asynchronous to CLK, high = pressed.
REQ-007 TICK  output  1  one-cycle pulse per elapsed millisecond while running; drives the J/K enables of the downstream flip-flop counter chain.
REQ-008 CLR  output  1  one-cycle pulse commanding the downstream counter chain to its reset value.
REQ-009 RUNNING  output  1  high while in state RUN.

Function
REQ-010 DIV SHALL equal CLK_FREQ_HZ/1000, and DEB_CYCLES SHALL equal DEBOUNCE_MS*DIV.
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each debouncer SHALL count consecutive cycles in which the synchronized level differs from the stable level. It SHALL clear the count when the levels match. On the cycle the count equals DEB_CYCLES-1 with the levels still differing, it SHALL copy the synchronized level into the stable level and clear the count.
REQ-013 A press event SHALL be a registered one-cycle pulse on a 0->1 transition of a stable level; releases SHALL generate no event.
REQ-014 The FSM SHALL have the states IDLE, RUN and PAUSE, with IDLE as the reset state.
REQ-015 On a start/stop event the FSM SHALL go IDLE->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-016 On a clear event the FSM SHALL go to IDLE from any state, assert CLR for exactly one cycle, and load the prescaler with 0.
REQ-017 When start/stop and clear events occur in the same cycle, clear SHALL win and the start/stop event SHALL be discarded.
REQ-018 The prescaler SHALL count 0..DIV-1 and wrap to 0, and SHALL advance only in RUN.
REQ-019 In PAUSE and IDLE the prescaler SHALL hold its value, so a paused interval resumes with its partial count preserved.
REQ-020 TICK SHALL be high for exactly one cycle when the prescaler equals DIV-1 in RUN. The first TICK after IDLE->RUN SHALL occur DIV cycles after RUNNING rises.
REQ-021 TICK SHALL be suppressed in any cycle where CLR is high. TICK and CLR SHALL never be high together.
REQ-022 With a button held high from cycle 0, RUNNING/CLR SHALL respond exactly 2+DEB_CYCLES+1 cycles later. A button held indefinitely SHALL produce exactly one event.
REQ-023 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no event.

Reset
REQ-024 RST_N low SHALL immediately set state IDLE; TICK, CLR and RUNNING 0; prescaler, debounce counters, synchronizers and stable levels 0; no clock is required.
REQ-025 Reset deassertion SHALL generate no event, even with a button held; that button must be released and pressed again.
REQ-026 Reset asserted mid-run SHALL abort any pending tick, and CLR SHALL NOT be pulsed.

Structure
REQ-027 The shared package ms_counter_pkg SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and the default CLK_FREQ_HZ.
REQ-028 The synchronizer, debouncer and edge detector SHALL form one sub-module, btn_debounce, instantiated twice. The prescaler and FSM SHALL reside in ms_tick_ctrl.
REQ-029 Counter widths SHALL be derived with $clog2 from DIV and DEB_CYCLES, with no hard-coded widths.

Verification (CLK_FREQ_HZ=10000, DEBOUNCE_MS=1 -> DIV=10, DEB_CYCLES=10)
REQ-030 Hold BTN_SS high from cycle 0 -> RUNNING=1 at cycle 13; TICK pulses at cycles 23, 33, 43; no second event while held.
REQ-031 Run 25 cycles, press SS (PAUSE) for 50 cycles, press SS again -> no TICK during PAUSE; after resume, TICK arrives after the remaining 5 of 10 prescaler counts.
REQ-032 Press BTN_SS and BTN_CLR in the same cycle from RUN -> CLR one pulse, state IDLE, RUNNING=0, no TICK that cycle.
REQ-033 Apply a 6-cycle BTN_SS glitch, then a 9-cycle BTN_SS glitch -> no event, RUNNING stays 0.
REQ-034 Drive RST_N low between clock edges while in RUN -> outputs 0 before the next edge. Release reset with BTN_SS held -> RUNNING stays 0 until release and re-press.
REQ-035 Assertions SHALL check that TICK and CLR are never high together and that each is never high for 2 consecutive cycles.
